// File: rtl/game_pkg.sv
// Shared game definitions: FSM phase encoding, tile-type codes used by the
// collision controller, score width and a saturating score adder.
package game_pkg;

   localparam int SCORE_W = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      DYING     = 3'd2,
      LEVEL_WON = 3'd3,
      GAME_OVER = 3'd4,
      GAME_WON  = 3'd5
   } game_state_t;

   localparam logic [1:0] TILE_EMPTY = 2'd0;
   localparam logic [1:0] TILE_WALL  = 2'd1;
   localparam logic [1:0] TILE_GIFT  = 2'd2;
   localparam logic [1:0] TILE_GOAL  = 2'd3;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky one-bit latch that condenses a multi-cycle strobe into one event per
// frame. On a startOfFrame cycle the held value is presented as frameEvent and
// the latch restarts from that cycle's strobe, so the strobe counts for the new
// frame.
module frame_event_latch (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic strobe,
   output logic frameEvent
);

   logic latch_q;
   logic latch_d;

   // hand-off reloads with the current strobe, otherwise accumulate
   always_comb begin
      latch_d = startOfFrame ? strobe : (latch_q | strobe);
   end

   // latch register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) latch_q <= 1'b0;
      else         latch_q <= latch_d;
   end

   assign frameEvent = startOfFrame & latch_q;

endmodule

// File: rtl/game_state_manager.sv
// Frame-rate game supervisor: per-frame event condensing, gift/lives/level/score
// bookkeeping and the game-phase FSM.
// Build option: define GSM_SCORE_EN to build the score register; without it
// score is tied to 0.
//
// state     | meaning
// IDLE      | after reset, waiting for startKey
// PLAY      | gameplay; frame events update counters
// DYING     | life lost, holding HOLD_FRAMES frames
// LEVEL_WON | level cleared, holding HOLD_FRAMES frames
// GAME_OVER | no lives left, waiting for startKey
// GAME_WON  | last level cleared, waiting for startKey
module game_state_manager
   import game_pkg::*;
#(
   parameter int NUM_GIFTS    = 8,
   parameter int NUM_LIVES    = 3,
   parameter int NUM_LEVELS   = 4,
   parameter int HOLD_FRAMES  = 60,
   parameter int GIFT_POINTS  = 10,
   parameter int LEVEL_POINTS = 100
) (
   input  logic                            clk,
   input  logic                            resetN,
   input  logic                            startOfFrame,
   input  logic                            startKey,
   input  logic                            Remove_Gift,
   input  logic                            victory,
   input  logic                            Loss,
   output logic                            gift_clear,
   output logic [$clog2(NUM_GIFTS+1)-1:0]  giftsRemaining,
   output logic [$clog2(NUM_LIVES+1)-1:0]  lives,
   output logic [$clog2(NUM_LEVELS)-1:0]   level,
   output logic [SCORE_W-1:0]              score,
   output logic                            playEnable,
   output logic                            levelRestart,
   output logic                            gameOver,
   output logic                            gameWon
);

   localparam int GW = $clog2(NUM_GIFTS+1);
   localparam int LW = $clog2(NUM_LIVES+1);
   localparam int VW = $clog2(NUM_LEVELS);
   localparam int HW = $clog2(HOLD_FRAMES+1);

   localparam logic [GW-1:0] GIFTS_FULL = GW'(NUM_GIFTS);
   localparam logic [LW-1:0] LIVES_FULL = LW'(NUM_LIVES);
   localparam logic [VW-1:0] LAST_LEVEL = VW'(NUM_LEVELS-1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES-1);

   game_state_t   state_q, state_d;
   logic [GW-1:0] gifts_q, gifts_d;
   logic [LW-1:0] lives_q, lives_d;
   logic [VW-1:0] level_q, level_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          restart_q, restart_d;
   logic          gift_clear_q, gift_clear_d;
   logic          score_clr, add_gift, add_level;

   logic gift_ev, victory_ev, loss_ev;

   frame_event_latch u_gift_latch (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .strobe       (Remove_Gift),
      .frameEvent   (gift_ev)
   );

   frame_event_latch u_victory_latch (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .strobe       (victory),
      .frameEvent   (victory_ev)
   );

   frame_event_latch u_loss_latch (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .strobe       (Loss),
      .frameEvent   (loss_ev)
   );

   // phase transitions and counter updates; events outside PLAY are simply not consumed
   always_comb begin
      state_d   = state_q;
      gifts_d   = gifts_q;
      lives_d   = lives_q;
      level_d   = level_q;
      hold_d    = hold_q;
      restart_d = 1'b0;
      score_clr = 1'b0;
      add_gift  = 1'b0;
      add_level = 1'b0;

      unique case (state_q)
         IDLE, GAME_OVER, GAME_WON: begin
            if (startKey) begin
               state_d   = PLAY;
               lives_d   = LIVES_FULL;
               level_d   = '0;
               gifts_d   = GIFTS_FULL;
               score_clr = 1'b1;
               restart_d = 1'b1;
            end
         end
         PLAY: begin
            if (startOfFrame) begin
               // gift_clear_q reflects the previous frame, so the last gift and a
               // victory in the same frame do not complete the level
               if (victory_ev && gift_clear_q) begin
                  state_d   = LEVEL_WON;
                  add_level = 1'b1;
               end else if (loss_ev) begin
                  state_d = DYING;
                  if (lives_q != '0) lives_d = lives_q - LW'(1);
               end else if (gift_ev && (gifts_q != '0)) begin
                  gifts_d  = gifts_q - GW'(1);
                  add_gift = 1'b1;
               end
            end
         end
         DYING: begin
            if (startOfFrame) begin
               if (hold_q == HOLD_LAST) begin
                  if (lives_q == '0) begin
                     state_d = GAME_OVER;
                  end else begin
                     state_d   = PLAY;
                     gifts_d   = GIFTS_FULL;
                     restart_d = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         LEVEL_WON: begin
            if (startOfFrame) begin
               if (hold_q == HOLD_LAST) begin
                  if (level_q == LAST_LEVEL) begin
                     state_d = GAME_WON;
                  end else begin
                     state_d   = PLAY;
                     level_d   = level_q + VW'(1);
                     gifts_d   = GIFTS_FULL;
                     restart_d = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) hold_d = '0;
      gift_clear_d = (gifts_d == '0);
   end

   // state and counter registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         gifts_q      <= GIFTS_FULL;
         lives_q      <= LIVES_FULL;
         level_q      <= '0;
         hold_q       <= '0;
         restart_q    <= 1'b0;
         gift_clear_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gifts_q      <= gifts_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         hold_q       <= hold_d;
         restart_q    <= restart_d;
         gift_clear_q <= gift_clear_d;
      end
   end

`ifdef GSM_SCORE_EN
   logic [SCORE_W-1:0] score_q, score_d;

   // new game clears, awards add with saturation
   always_comb begin
      score_d = score_q;
      if (score_clr)      score_d = '0;
      else if (add_level) score_d = sat_add(score_q, SCORE_W'(LEVEL_POINTS));
      else if (add_gift)  score_d = sat_add(score_q, SCORE_W'(GIFT_POINTS));
   end

   // score register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) score_q <= '0;
      else         score_q <= score_d;
   end

   assign score = score_q;
`else
   logic unused_score;
   assign unused_score = ^{score_clr, add_gift, add_level, GIFT_POINTS, LEVEL_POINTS};
   assign score        = '0;
`endif

   assign gift_clear     = gift_clear_q;
   assign giftsRemaining = gifts_q;
   assign lives          = lives_q;
   assign level          = level_q;
   assign levelRestart   = restart_q;
   assign playEnable     = (state_q == PLAY);
   assign gameOver       = (state_q == GAME_OVER);
   assign gameWon        = (state_q == GAME_WON);

endmodule

// File: tb/tb_game_state_manager.sv
// Testbench for game_state_manager. Expected score values follow the
// GSM_SCORE_EN build option (0 when the option is not defined).
module tb_game_state_manager;

`ifdef GSM_SCORE_EN
   localparam bit SCORE_ON = 1'b1;
`else
   localparam bit SCORE_ON = 1'b0;
`endif
   localparam int HOLD = 60;

   logic        clk, resetN, startOfFrame, startKey, Remove_Gift, victory, Loss;
   logic        gift_clear, playEnable, levelRestart, gameOver, gameWon;
   logic [3:0]  giftsRemaining;
   logic [1:0]  lives;
   logic [1:0]  level;
   logic [15:0] score;

   game_state_manager dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .startKey       (startKey),
      .Remove_Gift    (Remove_Gift),
      .victory        (victory),
      .Loss           (Loss),
      .gift_clear     (gift_clear),
      .giftsRemaining (giftsRemaining),
      .lives          (lives),
      .level          (level),
      .score          (score),
      .playEnable     (playEnable),
      .levelRestart   (levelRestart),
      .gameOver       (gameOver),
      .gameWon        (gameWon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit play; bit restart; bit clear;
      int gifts; int lives; int level; int score;
      bit over; bit won;
   } exp_t;

   typedef struct {
      bit g; bit v; bit l; int len;
      bit play; bit clear; int gifts; int score;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[12];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic exp_t mk(bit play, bit restart, bit clear, int gifts, int lv,
                               int lvl, int sc, bit over, bit won);
      exp_t e;
      e.play = play; e.restart = restart; e.clear = clear;
      e.gifts = gifts; e.lives = lv; e.level = lvl;
      e.score = SCORE_ON ? sc : 0;
      e.over = over; e.won = won;
      return e;
   endfunction

   task automatic cmp(string nm, int got, int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic check_pop(string nm);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.queue got empty want entry", nm);
      end else begin
         e = exp_q.pop_front();
         cmp({nm, ".playEnable"},     int'(playEnable),     int'(e.play));
         cmp({nm, ".levelRestart"},   int'(levelRestart),   int'(e.restart));
         cmp({nm, ".gift_clear"},     int'(gift_clear),     int'(e.clear));
         cmp({nm, ".giftsRemaining"}, int'(giftsRemaining), e.gifts);
         cmp({nm, ".lives"},          int'(lives),          e.lives);
         cmp({nm, ".level"},          int'(level),          e.level);
         cmp({nm, ".score"},          int'(score),          e.score);
         cmp({nm, ".gameOver"},       int'(gameOver),       int'(e.over));
         cmp({nm, ".gameWon"},        int'(gameWon),        int'(e.won));
      end
   endtask

   // entered and left at posedge+1
   task automatic run_frame(bit g, bit v, bit l, int len, bit sof_g, exp_t e,
                            string nm, bit do_check);
      Remove_Gift = g; victory = v; Loss = l;
      repeat (len) @(posedge clk);
      #1;
      Remove_Gift = 1'b0; victory = 1'b0; Loss = 1'b0;
      @(posedge clk); #1;
      startOfFrame = 1'b1;
      Remove_Gift  = sof_g;
      if (do_check) exp_q.push_back(e);
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      Remove_Gift  = 1'b0;
      if (do_check) check_pop(nm);
   endtask

   task automatic hold_frames(exp_t e_stay, exp_t e_exit, string nm);
      for (int i = 1; i <= HOLD; i++)
         run_frame(1'b0, 1'b0, 1'b0, 1, 1'b0, (i == HOLD) ? e_exit : e_stay,
                   $sformatf("%s.f%0d", nm, i), i >= HOLD - 1);
   endtask

   task automatic press_start(exp_t e, string nm);
      startKey = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      startKey = 1'b0;
      check_pop(nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          g  v  l  len  play clr gifts score
      vecs[0]  = '{1, 0, 0, 200, 1, 0, 7, 10};
      vecs[1]  = '{1, 0, 0, 3,   1, 0, 6, 20};
      vecs[2]  = '{0, 0, 0, 3,   1, 0, 6, 20};
      vecs[3]  = '{1, 0, 0, 2,   1, 0, 5, 30};
      vecs[4]  = '{1, 1, 0, 4,   1, 0, 4, 40};
      vecs[5]  = '{1, 0, 0, 1,   1, 0, 3, 50};
      vecs[6]  = '{0, 1, 0, 5,   1, 0, 3, 50};
      vecs[7]  = '{1, 0, 0, 1,   1, 0, 2, 60};
      vecs[8]  = '{1, 0, 0, 1,   1, 0, 1, 70};
      vecs[9]  = '{1, 0, 0, 1,   1, 1, 0, 80};
      vecs[10] = '{1, 0, 0, 2,   1, 1, 0, 80};
      vecs[11] = '{0, 1, 0, 3,   0, 1, 0, 180};

      resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0;
      Remove_Gift = 1'b0; victory = 1'b0; Loss = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back(mk(0, 0, 0, 8, 3, 0, 0, 0, 0));
      check_pop("reset");
      resetN = 1'b1;
      @(posedge clk); #1;

      press_start(mk(1, 1, 0, 8, 3, 0, 0, 0, 0), "start");
      exp_q.push_back(mk(1, 0, 0, 8, 3, 0, 0, 0, 0));
      @(posedge clk); #1;
      check_pop("start_pulse_end");

      for (int i = 0; i < 12; i++)
         run_frame(vecs[i].g, vecs[i].v, vecs[i].l, vecs[i].len, 1'b0,
                   mk(vecs[i].play, 0, vecs[i].clear, vecs[i].gifts, 3, 0, vecs[i].score, 0, 0),
                   $sformatf("vec%0d", i), 1'b1);

      hold_frames(mk(0, 0, 1, 0, 3, 0, 180, 0, 0), mk(1, 1, 0, 8, 3, 1, 180, 0, 0), "won_hold");

      run_frame(0, 0, 0, 1, 1'b1, mk(1, 0, 0, 8, 3, 1, 180, 0, 0), "sof_strobe_defer", 1'b1);
      run_frame(0, 0, 0, 1, 1'b0, mk(1, 0, 0, 7, 3, 1, 190, 0, 0), "sof_strobe_counts", 1'b1);
      press_start(mk(1, 0, 0, 7, 3, 1, 190, 0, 0), "start_ignored_in_play");

      run_frame(1, 0, 1, 3, 1'b0, mk(0, 0, 0, 7, 2, 1, 190, 0, 0), "loss_beats_gift", 1'b1);
      for (int i = 0; i < 5; i++)
         run_frame(0, 0, 0, 1, 1'b0, mk(0, 0, 0, 7, 2, 1, 190, 0, 0), "dying", 1'b0);
      Remove_Gift = 1'b1; Loss = 1'b1;
      @(posedge clk); #1;
      Remove_Gift = 1'b0; Loss = 1'b0;
      #2 resetN = 1'b0;
      #1;
      exp_q.push_back(mk(0, 0, 0, 8, 3, 0, 0, 0, 0));
      check_pop("async_reset");
      @(posedge clk); @(posedge clk); #1;
      resetN = 1'b1;
      @(posedge clk); #1;
      press_start(mk(1, 1, 0, 8, 3, 0, 0, 0, 0), "start_after_reset");
      run_frame(0, 0, 0, 1, 1'b0, mk(1, 0, 0, 8, 3, 0, 0, 0, 0), "no_stale_event", 1'b1);

      run_frame(1, 0, 0, 1, 1'b0, mk(1, 0, 0, 7, 3, 0, 10, 0, 0), "go_gift", 1'b1);
      run_frame(0, 0, 1, 1, 1'b0, mk(0, 0, 0, 7, 2, 0, 10, 0, 0), "go_loss1", 1'b1);
      startKey = 1'b1;
      @(posedge clk); #1;
      startKey = 1'b0;
      hold_frames(mk(0, 0, 0, 7, 2, 0, 10, 0, 0), mk(1, 1, 0, 8, 2, 0, 10, 0, 0), "go_hold1");
      run_frame(0, 0, 1, 2, 1'b0, mk(0, 0, 0, 8, 1, 0, 10, 0, 0), "go_loss2", 1'b1);
      hold_frames(mk(0, 0, 0, 8, 1, 0, 10, 0, 0), mk(1, 1, 0, 8, 1, 0, 10, 0, 0), "go_hold2");
      run_frame(0, 0, 1, 2, 1'b0, mk(0, 0, 0, 8, 0, 0, 10, 0, 0), "go_loss3", 1'b1);
      hold_frames(mk(0, 0, 0, 8, 0, 0, 10, 0, 0), mk(0, 0, 0, 8, 0, 0, 10, 1, 0), "go_hold3");
      press_start(mk(1, 1, 0, 8, 3, 0, 0, 0, 0), "start_after_over");

      for (int lvl = 0; lvl < 4; lvl++) begin
         for (int k = 0; k < 8; k++)
            run_frame(1, 0, 0, 1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "win_gift", 1'b0);
         run_frame(0, 1, 0, 1, 1'b0, mk(0, 0, 1, 0, 3, lvl, 180 * (lvl + 1), 0, 0),
                   $sformatf("win_victory%0d", lvl), 1'b1);
         hold_frames(mk(0, 0, 1, 0, 3, lvl, 180 * (lvl + 1), 0, 0),
                     (lvl < 3) ? mk(1, 1, 0, 8, 3, lvl + 1, 180 * (lvl + 1), 0, 0)
                               : mk(0, 0, 1, 0, 3, 3, 720, 0, 1),
                     $sformatf("win_hold%0d", lvl));
      end
      press_start(mk(1, 1, 0, 8, 3, 0, 0, 0, 0), "start_after_won");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_state_manager.md
# game_state_manager

Frame-rate game supervisor downstream of the collision controller. Condenses its per-pixel `Remove_Gift`, `victory` and `Loss` strobes into at most one event of each kind per frame. Keeps gift count, lives, level and score, and runs the game-phase state machine. Drives `gift_clear` back to the collision controller and `playEnable`/`levelRestart` to the ball and tile-map blocks.

## Interface
- `NUM_GIFTS`, 8: gifts per level; reload value.
- `NUM_LIVES`, 3: lives per new game.
- `NUM_LEVELS`, 4: levels per game; last level index is `NUM_LEVELS-1`.
- `HOLD_FRAMES`, 60: frames spent in `DYING` / `LEVEL_WON` before leaving.
- `GIFT_POINTS`, 10; `LEVEL_POINTS`, 100: score increments.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-cycle pulse per frame.
- `startKey`, in, 1: debounced one-cycle start pulse.
- `Remove_Gift`, `victory`, `Loss`, in, 1 each: raw overlap strobes; may be high for many cycles per frame.
- `gift_clear`, out, 1: registered; high when `giftsRemaining == 0`.
- `giftsRemaining`, out, `$clog2(NUM_GIFTS+1)`: gifts left.
- `lives`, out, `$clog2(NUM_LIVES+1)`: lives left.
- `level`, out, `$clog2(NUM_LEVELS)`: current level index.
- `score`, out, 16: unsigned score; saturates at `16'hFFFF`.
- `playEnable`, out, 1: high only in `PLAY`.
- `levelRestart`, out, 1: one-cycle pulse; tile map reloads gifts and ball returns to its start position.
- `gameOver`, `gameWon`, out, 1 each: high in the matching terminal state.

## Operation
**Event latches:** one per strobe (gift, victory, loss).
- Set on any cycle the strobe is high.
- On a `startOfFrame` cycle the current latched value is handed to the FSM as the frame's event. The latch is then reloaded with that cycle's strobe, which counts for the new frame.
- Events arriving outside `PLAY` are discarded at hand-off.

**FSM states:** `IDLE`, `PLAY`, `DYING`, `LEVEL_WON`, `GAME_OVER`, `GAME_WON`. All decisions are taken only on `startOfFrame` cycles, except `startKey`.
- **`IDLE`, `GAME_OVER`, `GAME_WON` + `startKey`:** go to `PLAY`.
  - Load `lives=NUM_LIVES`, `level=0`, `score=0`, `giftsRemaining=NUM_GIFTS`.
  - Pulse `levelRestart`.
- **`PLAY`, per frame, in this priority order:**
  1. Victory event with `gift_clear` already 1 before this frame: go to `LEVEL_WON`; `score += LEVEL_POINTS`.
  2. Loss event: go to `DYING`; `lives -= 1`.
  3. Gift event with `giftsRemaining > 0`: `giftsRemaining -= 1`; `score += GIFT_POINTS`.
  - A victory while gifts remain is ignored.
  - A gift event in the same frame as a taken victory or loss is dropped.
- **`DYING`:**
  - Count `HOLD_FRAMES` frames.
  - If `lives == 0`, go to `GAME_OVER`.
  - Otherwise go to `PLAY`, reload `giftsRemaining`, pulse `levelRestart`.
- **`LEVEL_WON`:**
  - Count `HOLD_FRAMES` frames.
  - If `level == NUM_LEVELS-1`, go to `GAME_WON`.
  - Otherwise go to `PLAY`, `level += 1`, reload gifts, pulse `levelRestart`.
- `startKey` is ignored in `PLAY`, `DYING` and `LEVEL_WON`.

**Arithmetic:**
- Score adds saturate at `16'hFFFF`; no wrap.
- `giftsRemaining` and `lives` never underflow.
- The hold counter is `$clog2(HOLD_FRAMES+1)` bits and resets to 0 on every state entry.

## Timing
**Reset values:**
- State `IDLE`.
- `giftsRemaining = NUM_GIFTS`, `lives = NUM_LIVES`, `level = 0`, `score = 0`.
- `gift_clear`, `playEnable`, `levelRestart`, `gameOver`, `gameWon` all 0.
- All latches cleared.

**Latency and ordering:**
- An event in frame N updates the counters and state in the cycle after the `startOfFrame` that ends frame N; outputs are registered.
- `gift_clear` rises in the same cycle as the final gift decrement. A victory is therefore accepted no earlier than the following frame.
- `levelRestart` is high for exactly one cycle: the first cycle with `playEnable = 1`.

**Reset mid-operation:** `resetN` low in any state returns every output to its reset value asynchronously; no pending event survives.

## Configuration
- **`GSM_SCORE_EN` defined:** score register, adders and saturation logic are built as described.
- **`GSM_SCORE_EN` undefined:**
  - `score` is tied to 0.
  - `GIFT_POINTS` and `LEVEL_POINTS` are unused.
  - All other behaviour is identical.

## Structure
- **Shared package `game_pkg`:**
  - Enum `game_state_t` with the six states.
  - Tile-type constants shared with the collision controller.
  - Score width constant `SCORE_W = 16`.
- **Sub-module `frame_event_latch`:**
  - One 1-bit sticky latch with the `startOfFrame` hand-off.
  - Outputs `frameEvent`.
  - Instantiated three times.

## Test plan
- **Start:** reset, `startKey` -> next cycle `playEnable=1`, `levelRestart=1` for one cycle, `giftsRemaining=8`, `lives=3`.
- **Gift debounce:** `Remove_Gift` high for 200 cycles within one frame -> after the next `startOfFrame`, `giftsRemaining=7`, `score=10`.
- **Early victory:** `victory` with 3 gifts left -> ignored, state stays `PLAY`. Collect all 8 gifts, then `victory` the following frame -> `LEVEL_WON`, `score=180`; after 60 frames `level=1`, `giftsRemaining=8`.
- **Game over:** three `Loss` events, each followed by 60 frames -> `lives` counts 2,1,0, then `gameOver=1`, `playEnable=0`; `startKey` -> new game with `score=0`.
- **Same-frame priority:** `Loss` and `Remove_Gift` in one frame -> `DYING`, gift count unchanged. `resetN` pulsed during `DYING` -> all reset values.
- **Build option:** win all 4 levels -> `gameWon=1`. Rebuild without `GSM_SCORE_EN` -> `score` stays 0 throughout.
